bram_playback: RTL

BRAM_PLAYBACK -- requirements
Module: bram_playback

---
 rtl/bram_pkg.sv | 21 ++
 rtl/bram_playback_if.sv | 30 +++
 rtl/bram_playback_pace_counter.sv | 27 ++
 rtl/bram_playback.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared BRAM definitions: default geometry and the playback FSM state encoding,
// also used by the EPP-to-BRAM controller.
package bram_pkg;

    localparam int BRAM_ADDR_W = 12;
    localparam int BRAM_DATA_W = 8;
    localparam int RATE_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_PACE  = 3'd4
    } bram_state_t;

    function automatic logic state_is_busy(bram_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/bram_playback_if.sv
// BRAM read port plus the outgoing byte stream of the playback engine.
interface bram_playback_if
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
);

    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;

    // Stream: a byte transfers on every rising edge where dout_valid and
    // dout_ready are both high; once raised, dout_valid stays high and dout
    // stays stable until that transfer (or an abort/reset) happens.
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output bram_en, bram_addr, dout, dout_valid,
        input  bram_dout, dout_ready
    );

    modport slave (
        input  bram_en, bram_addr, dout, dout_valid,
        output bram_dout, dout_ready
    );

endinterface

// File: rtl/bram_playback_pace_counter.sv
// Down-counter that spaces out stream bytes: load a value, count to zero.
module pace_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bram_playback.sv
// Plays a block of BRAM out as a valid/ready byte stream with optional pacing
// between bytes and optional endless looping over the block.
module bram_playback
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [RATE_W-1:0]   rate_div,
    output logic                busy,
    output logic                done,
    output bram_state_t         dbg_state,
    bram_playback_if.master     bus
);

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    bram_state_t         state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     rem_q;
    logic [ADDR_W:0]     len_q;
    logic [RATE_W-1:0]   div_q;
    logic                loop_q;
    logic [DATA_W-1:0]   dout_q;
    logic                done_q;

    logic                ld_start;
    logic                consume;
    logic                reload;
    logic                finish;
    logic                pace_load;
    logic                pace_en;
    logic                pace_zero;
    logic                proceed;
    logic                last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_start  = 1'b0;
        consume   = 1'b0;
        reload    = 1'b0;
        finish    = 1'b0;
        pace_load = 1'b0;
        pace_en   = 1'b0;
        proceed   = 1'b0;
        last      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ld_start = 1'b1;
                    if (length != '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_HOLD;
            ST_HOLD: begin
                if (bus.dout_ready) begin
                    consume = 1'b1;
                    if (div_q != '0) begin
                        pace_load = 1'b1;
                        state_d   = ST_PACE;
                    end else begin
                        // rem_q still counts the byte being consumed this cycle
                        proceed = 1'b1;
                        last    = (rem_q == REM_ONE);
                    end
                end
            end
            ST_PACE: begin
                if (pace_zero) begin
                    proceed = 1'b1;
                    last    = (rem_q == '0);
                end else begin
                    pace_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (proceed) begin
            if (!last) begin
                state_d = ST_ISSUE;
            end else if (loop_q) begin
                reload  = 1'b1;
                state_d = ST_ISSUE;
            end else begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // Abort cancels everything queued up for this edge, including done.
        if (abort) begin
            state_d   = ST_IDLE;
            ld_start  = 1'b0;
            consume   = 1'b0;
            reload    = 1'b0;
            finish    = 1'b0;
            pace_load = 1'b0;
            pace_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            base_q <= '0;
            rem_q  <= '0;
            len_q  <= '0;
            div_q  <= '0;
            loop_q <= 1'b0;
            dout_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (ld_start) begin
                base_q <= base_addr;
                len_q  <= length;
                div_q  <= rate_div;
                loop_q <= loop_en;
                addr_q <= base_addr;
                rem_q  <= length;
            end
            if (consume) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - REM_ONE;
            end
            if (reload) begin
                addr_q <= base_q;
                rem_q  <= len_q;
            end
            if (state_q == ST_WAIT) begin
                dout_q <= bus.bram_dout;
            end
        end
    end

    // Pacing starts right after a handshake, so the counter holds div-1 and
    // PACE lasts exactly rate_div cycles including the one that sees zero.
    pace_counter #(
        .W (RATE_W)
    ) u_pace (
        .clk      (clk),
        .rst      (rst),
        .load     (pace_load),
        .load_val (div_q - RATE_W'(1)),
        .en       (pace_en),
        .zero     (pace_zero)
    );

    assign bus.bram_en    = (state_q == ST_ISSUE);
    assign bus.bram_addr  = addr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == ST_HOLD);
    assign busy           = state_is_busy(state_q);
    assign done           = done_q;
    assign dbg_state      = state_q;

endmodule
